// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU front end:
//   - default address / instruction widths and fetch-queue depth
//   - fetch FSM state encoding (S_BOOT, S_RUN, S_FLUSH)
//   - sat_inc16: saturating 16-bit increment used by the optional stall
//     counter in instr_fetch (FETCH_PERF_EN)
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int ADDR_W_DEF      = 8;   // PC / ROM address width
  localparam int INSTR_W_DEF     = 15;  // opcode + 8-bit literal
  localparam int FETCH_DEPTH_DEF = 2;   // fetch-queue entries

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,  // one idle cycle after reset
    S_RUN   = 2'd1,  // normal issue
    S_FLUSH = 2'd2   // one cycle after a taken jump
  } fetch_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// DEPTH-entry queue of {instr, instr_pc} words between the ROM and the decoder.
// When empty, dout keeps showing the last head that was presented.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset (overrides clear/push/pop)
//   push   in   write din at the tail
//   pop    in   drop the head (caller only pops when count != 0)
//   clear  in   empty the queue; wins over push
//   din    in   WIDTH  entry to write
//   dout   out  WIDTH  head entry (last head when empty)
//   count  out  clog2(DEPTH)+1  number of stored entries
// DEPTH must be a power of two (pointers wrap by overflow).
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [WIDTH-1:0] hold_q;
  logic             not_empty;

  assign not_empty = (count != '0);
  assign dout      = not_empty ? mem[rd_ptr] : hold_q;

  // NOTE: the storage array has no reset; count/pointers define which words
  // are meaningful, so resetting the data would only cost flops.
  always_ff @(posedge clk) begin
    if (!reset && push && !clear) begin
      mem[wr_ptr] <= din;
    end
  end

  // NOTE: all sequential state uses <= so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold_q <= '0;
    end else begin
      // Remember the presented head so it stays visible once the queue drains.
      if (not_empty) begin
        hold_q <= mem[rd_ptr];
      end
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        unique case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Fetch stage between the PC and the control unit. Issues pc_in to a
// synchronous ROM (1-cycle latency), tags the returning word with its address,
// queues it in fetch_fifo and offers {instr, instr_pc} over valid/ready.
// Issue is gated so queued + in-flight words never exceed DEPTH; pc_hold tells
// the PC not to advance. flush (taken jump) drops queued and in-flight words.
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   pc_in        in   ADDR_W   address to fetch this cycle
//   flush        in   taken jump this cycle; discard older fetches
//   pc_hold      out  1 = PC must not advance
//   rom_en       out  ROM read strobe
//   rom_addr     out  ADDR_W   ROM address (= pc_in)
//   rom_rdata    in   INSTR_W  ROM data, valid the cycle after rom_en
//   instr        out  INSTR_W  head-of-queue instruction
//   instr_pc     out  ADDR_W   address of instr
//   instr_valid  out  instr/instr_pc valid
//   dec_ready    in   decoder accepts head when instr_valid & dec_ready
//   stall_cycles out  16       (only with FETCH_PERF_EN) saturating count of
//                              S_RUN cycles with pc_hold=1
// Build option: define FETCH_PERF_EN to add stall_cycles.
// -----------------------------------------------------------------------------
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DEPTH   = FETCH_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               flush,
  output logic               pc_hold,
  output logic               rom_en,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
`ifdef FETCH_PERF_EN
  output logic [15:0]        stall_cycles,
`endif
  input  logic               dec_ready
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = INSTR_W + ADDR_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  fetch_state_e       state_q, state_d;
  logic               inflight_q;
  logic [ADDR_W-1:0]  tag_q;
  logic [CNT_W-1:0]   count;
  logic [ENTRY_W-1:0] head;
  logic               room;
  logic               push;
  logic               pop;

  // Reserve a slot for the word already in flight so the queue cannot overflow
  // even if the decoder stalls while that word returns.
  assign room = (count + CNT_W'(inflight_q)) < DEPTH_C;

  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latches).
    state_d = state_q;
    rom_en  = 1'b0;
    pc_hold = 1'b1;
    unique case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        rom_en  = ~flush & room;
        pc_hold = ~rom_en;
        if (flush) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        // PC loads the jump target now; nothing is issued this cycle.
        pc_hold = 1'b0;
        state_d = flush ? S_FLUSH : S_RUN;
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_BOOT;
      inflight_q <= 1'b0;
      tag_q      <= '0;
    end else begin
      state_q    <= state_d;
      // rom_en is low in the flush cycle, so a flush also empties this slot.
      inflight_q <= rom_en;
      if (rom_en) tag_q <= pc_in;
    end
  end

  assign rom_addr    = pc_in;
  assign instr_valid = (count != '0);
  assign pop         = instr_valid & dec_ready;
  // A word returning during a flush is wrong-path: flush beats push.
  assign push        = inflight_q & ~flush & (state_q == S_RUN);

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (flush),
    .din   ({rom_rdata, tag_q}),
    .dout  (head),
    .count (count)
  );

  assign {instr, instr_pc} = head;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if ((state_q == S_RUN) && pc_hold) begin
      stall_cycles <= sat_inc16(stall_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Bench for instr_fetch. A ROM model returns addr+0x100 one cycle after rom_en;
// a PC model advances whenever pc_hold is low and pushes the expected
// {instr, pc} into a scoreboard; every decoder handshake pops and compares.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 15;
  localparam int DEPTH   = 2;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [ADDR_W-1:0]  pc_in = '0;
  logic               flush = 1'b0;
  logic               pc_hold;
  logic               rom_en;
  logic [ADDR_W-1:0]  rom_addr;
  logic [INSTR_W-1:0] rom_rdata = '0;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               dec_ready = 1'b0;
`ifdef FETCH_PERF_EN
  logic [15:0]        stall_cycles;
`endif

  exp_t              sb[$];
  exp_t              mon_e;
  int                n_cmp = 0;
  int                n_bad = 0;
  logic              hold_at_neg = 1'b1;
  logic [ADDR_W-1:0] pc = '0;
  logic              last_pushed = 1'b0;

  always #5 clk = ~clk;

  instr_fetch #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_in        (pc_in),
    .flush        (flush),
    .pc_hold      (pc_hold),
    .rom_en       (rom_en),
    .rom_addr     (rom_addr),
    .rom_rdata    (rom_rdata),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
`ifdef FETCH_PERF_EN
    .stall_cycles (stall_cycles),
`endif
    .dec_ready    (dec_ready)
  );

  function automatic logic [INSTR_W-1:0] rom_val(input logic [ADDR_W-1:0] a);
    return {7'd0, a} + 15'h100;
  endfunction

  // Synchronous ROM model.
  always @(posedge clk) begin
    if (rom_en) rom_rdata <= rom_val(rom_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: scoreboard compare on every accepted handshake.
  always @(negedge clk) begin
    hold_at_neg = pc_hold;
    if (!reset) begin
      if (rom_en) check("rom_addr", 32'(rom_addr), 32'(pc_in));
      if (instr_valid && dec_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_pop", 32'(instr_valid), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("instr", 32'(instr), 32'(mon_e.instr));
          check("instr_pc", 32'(instr_pc), 32'(mon_e.pc));
        end
      end
    end
  end

  // One clock of the PC model: advance and expect a fetch when pc_hold was low.
  task automatic step();
    exp_t e;
    @(posedge clk);
    last_pushed = 1'b0;
    if (!reset && hold_at_neg === 1'b0) begin
      e.instr = rom_val(pc);
      e.pc    = pc;
      sb.push_back(e);
      pc = pc + 8'd1;
      last_pushed = 1'b1;
    end
    #1;
    pc_in = pc;
  endtask

  task automatic do_reset(input logic [ADDR_W-1:0] start);
    reset = 1'b1;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    pc    = start;
    pc_in = start;
  endtask

  // Caller has already raised flush for the current cycle.
  task automatic jump(input logic [ADDR_W-1:0] target);
    @(posedge clk);
    #1;
    flush = 1'b0;
    sb.delete();
    @(negedge clk);
    check("sflush_valid", 32'(instr_valid), 32'd0);
    check("sflush_rom_en", 32'(rom_en), 32'd0);
    check("sflush_hold", 32'(pc_hold), 32'd0);
    @(posedge clk);
    #1;
    pc    = target;
    pc_in = target;
  endtask

  task automatic run_until_valid(input logic [ADDR_W-1:0] exp_pc, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        check(tag, 32'(instr_pc), 32'(exp_pc));
        seen = 1'b1;
      end
      step();
    end
    if (!seen) check(tag, 32'(instr_valid), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state, first-fetch latency, streaming
    do_reset(8'd0);
    dec_ready = 1'b1;
    @(negedge clk);
    check("boot_valid", 32'(instr_valid), 32'd0);
    check("boot_instr", 32'(instr), 32'd0);
    check("boot_pc", 32'(instr_pc), 32'd0);
    check("boot_hold", 32'(pc_hold), 32'd1);
    check("boot_rom_en", 32'(rom_en), 32'd0);
    step();
    @(negedge clk);
    check("run0_rom_en", 32'(rom_en), 32'd1);
    check("run0_valid", 32'(instr_valid), 32'd0);
    step();
    @(negedge clk);
    check("run1_valid", 32'(instr_valid), 32'd0);
    step();
    @(negedge clk);
    check("run2_valid", 32'(instr_valid), 32'd1);
    check("run2_instr", 32'(instr), 32'h100);
    check("run2_pc", 32'(instr_pc), 32'd0);
    repeat (20) step();

    // 2: decoder stall fills the queue, then drains in order
    do_reset(8'd0);
    dec_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_hold", 32'(pc_hold), 32'(i >= 2));
      step();
    end
    @(negedge clk);
    check("stall_valid", 32'(instr_valid), 32'd1);
    check("stall_head_pc", 32'(instr_pc), 32'd0);
    dec_ready = 1'b1;
    repeat (15) step();

    // 3: flush with full queue (pcs 4,5), jump to 20
    do_reset(8'd4);
    dec_ready = 1'b0;
    repeat (6) step();
    @(negedge clk);
    check("full_hold", 32'(pc_hold), 32'd1);
    check("full_head_pc", 32'(instr_pc), 32'd4);
    flush = 1'b1;
    jump(8'd20);
    dec_ready = 1'b1;
    run_until_valid(8'd20, "after_flush_pc");
    repeat (6) step();

    // 4: flush in a cycle that pops the head and has a word in flight
    begin
      bit found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
        step();
        @(negedge clk);
        if (last_pushed && instr_valid) found = 1'b1;
      end
      check("flush_pop_setup", 32'(instr_valid), 32'd1);
      flush = 1'b1;
      jump(8'd40);
      run_until_valid(8'd40, "after_flush_pop_pc");
      repeat (6) step();
    end

    // 5: reset (with flush) while the queue is full
    dec_ready = 1'b0;
    repeat (6) step();
    @(negedge clk);
    check("pre_reset_valid", 32'(instr_valid), 32'd1);
    reset = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_hold", 32'(pc_hold), 32'd1);
    check("rst_rom_en", 32'(rom_en), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    do_reset(8'd0);
    dec_ready = 1'b1;
    repeat (10) step();

`ifdef FETCH_PERF_EN
    // 6: stall counter, exact count then saturation
    do_reset(8'd0);
    dec_ready = 1'b0;
    @(negedge clk);
    check("perf_reset", 32'(stall_cycles), 32'd0);
    repeat (13) step();
    @(negedge clk);
    check("perf_10", 32'(stall_cycles), 32'd10);
    repeat (70000) step();
    @(negedge clk);
    check("perf_sat", 32'(stall_cycles), 32'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
